// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control sequencer:
// state encodings, reset defaults and instruction field helpers.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } cpu_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP  = 32'd4;

  // J target and BBT offset field widths, plus the PC region bits kept on a jump
  localparam int unsigned J_TARGET_W    = 26;
  localparam int unsigned BBT_IMM_W     = 16;
  localparam int unsigned PC_REGION_LSB = 28;

  function automatic logic [31:0] bbt_offset(input logic [BBT_IMM_W-1:0] imm);
    return {{14{imm[BBT_IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_pc_next.sv
// Combinational next-PC calculator used at instruction retire.
// Priority: jump, then taken branch-on-bit, then sequential step.
module cpu_pc_next
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_STEP = DEF_PC_STEP
) (
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        jmp,
  input  logic        bbt_taken,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic        unused_opcode;

  assign seq_pc        = pc + PC_STEP;
  assign unused_opcode = ^inst[31:J_TARGET_W];

  always_comb begin
    next_pc = seq_pc;
    if (jmp) begin
      next_pc = {pc[31:PC_REGION_LSB], inst[J_TARGET_W-1:0], 2'b00};
    end else if (bbt_taken) begin
      next_pc = seq_pc + bbt_offset(inst[BBT_IMM_W-1:0]);
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch, decode, execute, memory, writeback,
// with PC ownership, halt-on-invalid and a retired-instruction counter.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic        dec_wen,
  input  logic [4:0]  dec_waddr,
  input  logic        dec_mem_rd,
  input  logic        dec_mem_wr,
  input  logic        dec_jmp,
  input  logic        dec_bbt,
  input  logic        dec_invalid,
  input  logic        bbt_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instret
);

  cpu_state_e  st;
  logic        bbt_q;
  logic        take_bbt;
  logic        retire;
  logic        is_mem;
  logic [31:0] next_pc;

  assign imem_addr = pc;
  assign state     = st;
  assign is_mem    = dec_mem_rd | dec_mem_wr;

  // A branch retiring straight out of EX must see the live condition; the
  // latched copy only matters if the branch were to pass through later states.
  assign take_bbt = dec_bbt & ((st == ST_EX) ? bbt_taken : bbt_q);

  always_comb begin
    retire = 1'b0;
    case (st)
      ST_EX:   retire = !is_mem && !dec_wen;
      ST_MEM:  retire = dmem_ack && dec_mem_wr;
      ST_WB:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  cpu_pc_next #(
    .PC_STEP(PC_STEP)
  ) u_pc_next (
    .pc       (pc),
    .inst     (inst),
    .jmp      (dec_jmp),
    .bbt_taken(take_bbt),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st       <= ST_IF;
      pc       <= RESET_PC;
      inst     <= '0;
      instret  <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      halted   <= 1'b0;
      bbt_q    <= 1'b0;
    end else begin
      rf_wen <= 1'b0;

      if (retire) begin
        st       <= ST_IF;
        pc       <= next_pc;
        instret  <= instret + 32'd1;
        imem_req <= 1'b1;
      end

      case (st)
        ST_IF: begin
          // Request is registered, so the first IF cycle after reset only raises it
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            inst     <= imem_rdata;
            imem_req <= 1'b0;
            st       <= ST_ID;
          end
        end
        ST_ID: begin
          if (dec_invalid) begin
            st     <= ST_HALT;
            halted <= 1'b1;
          end else begin
            st <= ST_EX;
          end
        end
        ST_EX: begin
          bbt_q <= bbt_taken;
          if (is_mem) begin
            st       <= ST_MEM;
            dmem_req <= 1'b1;
            dmem_we  <= dec_mem_wr;
          end else if (dec_wen) begin
            st       <= ST_WB;
            rf_wen   <= 1'b1;
            rf_waddr <= dec_waddr;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (!dec_mem_wr) begin
              st       <= ST_WB;
              rf_wen   <= 1'b1;
              rf_waddr <= dec_waddr;
            end
          end
        end
        ST_WB: begin
        end
        ST_HALT: begin
        end
        default: begin
          st       <= ST_HALT;
          halted   <= 1'b1;
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with a small MIPS-like decoder model;
// walks ALU, load, store, branch, jump, wrap, halt and reset scenarios.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic        dec_wen;
  logic [4:0]  dec_waddr;
  logic        dec_mem_rd;
  logic        dec_mem_wr;
  logic        dec_jmp;
  logic        dec_bbt;
  logic        dec_invalid;
  logic        bbt_taken = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instret;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_LW   = 32'h8C25_0000;
  localparam logic [31:0] I_SW   = 32'hAC25_0000;
  localparam logic [31:0] I_BM2  = 32'h1022_FFFE;
  localparam logic [31:0] I_BM5  = 32'h1022_FFFB;
  localparam logic [31:0] I_J40  = 32'h0800_0040;
  localparam logic [31:0] I_JMAX = 32'h0BFF_FFFF;
  localparam logic [31:0] I_BAD  = 32'h0C00_0000;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .dec_wen    (dec_wen),
    .dec_waddr  (dec_waddr),
    .dec_mem_rd (dec_mem_rd),
    .dec_mem_wr (dec_mem_wr),
    .dec_jmp    (dec_jmp),
    .dec_bbt    (dec_bbt),
    .dec_invalid(dec_invalid),
    .bbt_taken  (bbt_taken),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .pc         (pc),
    .state      (state),
    .halted     (halted),
    .instret    (instret)
  );

  // Decoder model: R-type(0), J(2), BBT(4), LW(0x23), SW(0x2B); all else illegal
  always_comb begin
    dec_wen     = 1'b0;
    dec_waddr   = '0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_jmp     = 1'b0;
    dec_bbt     = 1'b0;
    dec_invalid = 1'b0;
    case (inst[31:26])
      6'h00: begin dec_wen = 1'b1; dec_waddr = inst[15:11]; end
      6'h02: dec_jmp = 1'b1;
      6'h04: dec_bbt = 1'b1;
      6'h23: begin dec_wen = 1'b1; dec_mem_rd = 1'b1; dec_waddr = inst[20:16]; end
      6'h2B: dec_mem_wr = 1'b1;
      default: dec_invalid = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Expects IF with imem_req high; acks in the first request cycle
  task automatic fetch(input logic [31:0] word, input logic [31:0] exp_pc);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    chk("fetch_id", {29'd0, state}, 32'd1);
    chk("fetch_inst", inst, word);
  endtask

  int unsigned viol;

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_ctl", {26'd0, imem_req, dmem_req, dmem_we, rf_wen, halted, 1'b0}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    resetn = 1'b1;
    tick();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);

    // ADD $3: IF ID EX WB
    fetch(I_ADD, 32'h0);
    tick();
    chk("add_ex", {29'd0, state}, 32'd2);
    tick();
    chk("add_wb", {29'd0, state}, 32'd4);
    chk("add_rfwen", {31'd0, rf_wen}, 32'd1);
    chk("add_waddr", {27'd0, rf_waddr}, 32'd3);
    tick();
    chk("add_if", {29'd0, state}, 32'd0);
    chk("add_rfwen_off", {31'd0, rf_wen}, 32'd0);
    chk("add_pc", pc, 32'h4);
    chk("add_instret", instret, 32'd1);

    // LW $5 with ack in third MEM cycle
    fetch(I_LW, 32'h4);
    tick();
    tick();
    chk("lw_mem", {29'd0, state}, 32'd3);
    chk("lw_req1", {30'd0, dmem_req, dmem_we}, 32'b10);
    tick();
    chk("lw_req2", {31'd0, dmem_req}, 32'd1);
    tick();
    chk("lw_req3", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("lw_wb", {29'd0, state}, 32'd4);
    chk("lw_req_off", {31'd0, dmem_req}, 32'd0);
    chk("lw_rf", {26'd0, rf_wen, rf_waddr}, {26'd0, 1'b1, 5'd5});
    tick();
    chk("lw_pc", pc, 32'h8);
    chk("lw_instret", instret, 32'd2);

    // BBT taken at 8, offset -2 words
    fetch(I_BM2, 32'h8);
    tick();
    chk("bbt_ex", {29'd0, state}, 32'd2);
    bbt_taken = 1'b1;
    tick();
    bbt_taken = 1'b0;
    chk("bbt_t_state", {29'd0, state}, 32'd0);
    chk("bbt_t_pc", pc, 32'h4);
    chk("bbt_t_instret", instret, 32'd3);

    // BBT not taken at 4
    fetch(I_BM2, 32'h4);
    tick();
    tick();
    chk("bbt_nt_pc", pc, 32'h8);
    chk("bbt_nt_instret", instret, 32'd4);

    // SW: store, no writeback
    fetch(I_SW, 32'h8);
    tick();
    tick();
    chk("sw_req", {30'd0, dmem_req, dmem_we}, 32'b11);
    chk("sw_rfwen", {31'd0, rf_wen}, 32'd0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sw_if", {29'd0, state}, 32'd0);
    chk("sw_done", {30'd0, dmem_req, rf_wen}, 32'd0);
    chk("sw_pc", pc, 32'hC);
    chk("sw_instret", instret, 32'd5);

    // Branch backwards past zero: 12 + 4 - 20 wraps to FFFF_FFFC
    fetch(I_BM5, 32'hC);
    tick();
    bbt_taken = 1'b1;
    tick();
    bbt_taken = 1'b0;
    chk("bbt_wrap_pc", pc, 32'hFFFF_FFFC);

    // Jump keeps pc[31:28]
    fetch(I_J40, 32'hFFFF_FFFC);
    tick();
    chk("j_ex_quiet", {30'd0, rf_wen, dmem_req}, 32'd0);
    tick();
    chk("j_pc", pc, 32'hF000_0100);
    chk("j_instret", instret, 32'd7);

    fetch(I_JMAX, 32'hF000_0100);
    tick();
    tick();
    chk("jmax_pc", pc, 32'hFFFF_FFFC);

    // Sequential fetch at top of address space wraps to 0
    fetch(I_ADD, 32'hFFFF_FFFC);
    repeat (3) tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_instret", instret, 32'd9);

    // Illegal opcode halts; acks outside IF are ignored
    fetch(I_BAD, 32'h0);
    tick();
    chk("halt_state", {29'd0, state}, 32'd5);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    viol = 0;
    imem_ack   = 1'b1;
    imem_rdata = I_ADD;
    for (int i = 0; i < 20; i++) begin
      if (imem_req || dmem_req) viol++;
      tick();
    end
    imem_ack   = 1'b0;
    imem_rdata = '0;
    chk("halt_noreq", viol, 32'd0);
    chk("halt_pc", pc, 32'h0);
    chk("halt_instret", instret, 32'd9);
    chk("halt_inst", inst, I_BAD);
    chk("halt_still", {29'd0, state}, 32'd5);

    // Reset out of HALT, then reset again while in MEM
    resetn = 1'b0;
    #1;
    chk("halt_rst", {31'd0, halted}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    fetch(I_LW, 32'h0);
    tick();
    tick();
    chk("mem_before_rst", {31'd0, dmem_req}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("mem_rst_req", {30'd0, dmem_req, imem_req}, 32'd0);
    chk("mem_rst_state", {29'd0, state}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rel_state", {29'd0, state}, 32'd0);
    chk("rel_pc", pc, 32'h0);
    chk("rel_instret", instret, 32'd0);
    chk("rel_req", {31'd0, imem_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the single-issue CPU core.
- Fetches each instruction over the instruction-memory handshake and holds it in the instruction register.
- Feeds the instruction register to the instruction decoder, then steps the datapath through EX / MEM / WB using the decoder's control flags.
- Owns the PC, register-file write strobe, data-memory handshake, halt-on-invalid and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  single core clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- inst  out  32  instruction register, drives decoder inst input.
- dec_wen  in  1  decoder write-enable flag.
- dec_waddr  in  5  decoder destination register.
- dec_mem_rd  in  1  decoder load flag.
- dec_mem_wr  in  1  decoder store flag.
- dec_jmp  in  1  decoder jump flag.
- dec_bbt  in  1  decoder branch-on-bit flag.
- dec_invalid  in  1  decoder illegal-instruction flag.
- bbt_taken  in  1  branch condition from the datapath; sampled in EX.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_ack  in  1  data-memory transfer complete.
- rf_wen  out  1  register-file write strobe; one-cycle pulse.
- rf_waddr  out  5  register-file write address; valid while rf_wen is high.
- pc  out  32  current program counter.
- state  out  3  current FSM state, for debug.
- halted  out  1  core stopped on an illegal instruction.
- instret  out  32  retired-instruction count.

Behaviour:
- Reset values (asynchronous, resetn low):
  - state = IF, pc = RESET_PC, inst = 0, instret = 0.
  - imem_req, dmem_req, dmem_we, rf_wen and halted are all 0; rf_waddr = 0.
  - Asserting reset mid-transaction drops imem_req and dmem_req immediately, with no ack wait.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are unreachable; if ever entered they go to HALT.
- IF:
  - imem_req = 1 and imem_addr = pc, held until imem_ack.
  - On the ack cycle: inst <= imem_rdata, go to ID.
  - An ack in the first request cycle is legal, giving a one-cycle fetch.
  - imem_ack outside IF is ignored.
- ID:
  - Exactly one cycle; the decoder settles on inst.
  - dec_invalid = 1 -> HALT, otherwise -> EX.
- EX:
  - Exactly one cycle; bbt_taken is sampled here.
  - dec_mem_rd or dec_mem_wr -> MEM.
  - Else dec_wen -> WB.
  - Else -> IF, retiring the instruction.
- MEM:
  - dmem_req = 1 and dmem_we = dec_mem_wr, held until dmem_ack.
  - On ack: a load goes to WB; a store goes to IF and retires.
  - If both dec_mem_rd and dec_mem_wr are set, the store takes priority.
- WB:
  - rf_wen = 1 and rf_waddr = dec_waddr for exactly one cycle, then IF and retire.
- Retire, on the transition into IF:
  - instret <= instret + 1, wrapping modulo 2^32.
  - PC update priority:
    - dec_jmp: pc <= {pc[31:28], inst[25:0], 2'b00}.
    - dec_bbt and bbt_taken (as latched in EX): pc <= pc + PC_STEP + (sign-extended inst[15:0] << 2).
    - Otherwise: pc <= pc + PC_STEP.
  - All PC arithmetic is 32-bit and wraps silently; fetching at 32'hFFFF_FFFC yields next pc 0.
- HALT:
  - halted = 1; no requests issued; pc, instret and inst are frozen.
  - Only resetn exits HALT.
- Latency:
  - ALU op: 4 cycles (fetch ack in first cycle).
  - Load: 5 cycles plus memory wait.
  - Store: 4 cycles plus memory wait.
  - Jump or untaken branch: 3 cycles.
- Register timing: outputs are registered or decoded from state only; no combinational path from imem_ack or dmem_ack to any request output.

Decomposition:
- Shared package cpu_pkg:
  - State encodings ST_IF to ST_HALT.
  - RESET_PC default.
  - Opcode field constants for J and BBT offset extraction.
- One natural sub-module: cpu_pc_next, a combinational next-PC calculator (pc, inst, jmp, bbt_taken -> next_pc).
- The FSM, instruction register and counters stay in cpu_ctrl_fsm.

Test Plan:
- ADD: reset with RESET_PC=0; fetch 32'h00221820 (add $3,$1,$2), imem_ack in the first cycle -> ID, EX, WB. rf_wen pulses once with rf_waddr=3; pc=4; instret=1 after 4 cycles.
- LW: fetch 32'h8C250000 (lw $5,0($1)), dmem_ack delayed 3 cycles -> dmem_req high 3 cycles with dmem_we=0, then WB with rf_waddr=5; pc=4.
- SW: fetch 32'hAC250000 -> dmem_req with dmem_we=1 until ack; no rf_wen; retire to IF with pc=4.
- Jump: J at pc=32'h1000_0010 with inst[25:0]=26'h0000040 -> no rf_wen, no dmem_req; pc=32'h1000_0100.
- BBT: at pc=8 with offset 16'hFFFE -> bbt_taken=1 gives pc=4; bbt_taken=0 gives pc=12.
- Invalid and reset:
  - Invalid opcode 32'h0C000000 -> HALT; halted=1; no imem_req for 20 cycles.
  - Drop resetn while in MEM with dmem_req high -> dmem_req falls immediately; state=IF, pc=0 and instret=0 once released.
